// File: rtl/reg_temp_pkg.sv
// Shared defaults, word type and occupancy-width helper for the reg_temp pipeline slice.
package reg_temp_pkg;

    localparam int DATA_W_DEF = 32;
    localparam logic [31:0] RESET_VAL_DEF = 32'h0;

    typedef logic [31:0] word_t;

    // Bits needed to count 0..depth valid stages.
    function automatic int clog2_occ(input int depth);
        int w;
        w = 0;
        while ((1 << w) < (depth + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/reg_temp_stage.sv
// One elastic pipeline stage: a WIDTH-bit data register plus its valid bit.
module reg_temp_stage
    import reg_temp_pkg::*;
#(
    parameter int    WIDTH       = DATA_W_DEF,
    parameter word_t RESET_VALUE = RESET_VAL_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             up_valid,
    input  logic [WIDTH-1:0] up_data,
    input  logic             dn_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             rdy
);

    // An empty stage always accepts, which lets bubbles collapse under a downstream stall.
    assign rdy = !valid || dn_ready;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid <= 1'b0;
            data  <= WIDTH'(RESET_VALUE);
        end else if (flush) begin
            valid <= 1'b0;
        end else if (rdy) begin
            valid <= up_valid;
            data  <= up_data;
        end
    end

endmodule

// File: rtl/reg_temp_pipe.sv
// DEPTH-stage elastic pipeline register with stall propagation and synchronous flush.
// Optional statistics (stall_cnt, occupancy) are built when REG_TEMP_PIPE_STATS_EN is defined.
module reg_temp_pipe
    import reg_temp_pkg::*;
#(
    parameter int    WIDTH       = DATA_W_DEF,
    parameter int    DEPTH       = 1,
    parameter word_t RESET_VALUE = RESET_VAL_DEF
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          flush,
    input  logic                          in_valid,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          in_ready,
    output logic                          out_valid,
    output logic [WIDTH-1:0]              out_data,
    input  logic                          out_ready
`ifdef REG_TEMP_PIPE_STATS_EN
    ,
    output logic [31:0]                   stall_cnt,
    output logic [clog2_occ(DEPTH)-1:0]   occupancy
`endif
);

    // Handshake: a word moves across an interface on a rising edge where valid && ready.
    // valid never waits on ready; ready is a purely combinational chain from out_ready back
    // to in_ready, and a holder keeps its data stable while valid && !ready.
    logic [DEPTH-1:0] stg_valid;
    logic [WIDTH-1:0] stg_data [DEPTH];
    logic [DEPTH:0]   rdy;

    assign rdy[DEPTH] = out_ready;
    assign in_ready   = rdy[0];
    assign out_valid  = stg_valid[DEPTH-1];
    assign out_data   = stg_data[DEPTH-1];

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic             up_v;
        logic [WIDTH-1:0] up_d;

        if (k == 0) begin : g_head
            assign up_v = in_valid;
            assign up_d = in_data;
        end else begin : g_body
            assign up_v = stg_valid[k-1];
            assign up_d = stg_data[k-1];
        end

        reg_temp_stage #(
            .WIDTH       (WIDTH),
            .RESET_VALUE (RESET_VALUE)
        ) u_stage (
            .clk      (clk),
            .reset    (reset),
            .flush    (flush),
            .up_valid (up_v),
            .up_data  (up_d),
            .dn_ready (rdy[k+1]),
            .valid    (stg_valid[k]),
            .data     (stg_data[k]),
            .rdy      (rdy[k])
        );
    end

`ifdef REG_TEMP_PIPE_STATS_EN
    localparam int OCC_W = clog2_occ(DEPTH);

    // Saturating count of cycles where the consumer is holding off a valid word.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    // Derived from the valid bits, so reset and flush clear it with them.
    always_comb begin
        occupancy = '0;
        for (int k = 0; k < DEPTH; k++) begin
            occupancy = occupancy + OCC_W'(stg_valid[k]);
        end
    end
`endif

endmodule
